// File: rtl/privacy_pkg.sv
// Shared types and constants for the privacy release unit.
//   release_mode_e  : release policy selector (PASS, GATED, RANDOM, BUDGET)
//   LFSR_TAPS       : feedback mask of the 16-bit right-shifting Fibonacci LFSR
//   release_entry_t : queued decision, class index plus noise flag
package privacy_pkg;

   localparam int unsigned CLASS_W_DEF = 4;

   // Polynomial x^16+x^14+x^13+x^11 with the register shifting right:
   // the feedback bit is the XOR of state bits 0, 2, 3 and 5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   typedef enum logic [1:0] {
      REL_PASS   = 2'd0,
      REL_GATED  = 2'd1,
      REL_RANDOM = 2'd2,
      REL_BUDGET = 2'd3
   } release_mode_e;

   typedef struct packed {
      logic [CLASS_W_DEF-1:0] cls;
      logic                   noise;
   } release_entry_t;

endpackage

// File: rtl/privacy_result_fifo.sv
// Generic synchronous FIFO with a registered head.
//   push/wr_data    : enqueue request and payload
//   out_ready       : downstream ready; a pop happens on out_valid & out_ready
//   out_valid       : registered, high while the queue holds an entry
//   rd_data         : registered head; holds its last value while empty
//   push_accept_c   : combinational, push accepted this cycle (not full, or popping)
module privacy_result_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic             push_accept_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_n;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_after_pop;
   logic [CNT_W-1:0] count_n;
   logic             full;
   logic             pop;

   assign full          = (count == CNT_W'(DEPTH));
   assign pop           = out_valid & out_ready;
   assign push_accept_c = push & (!full | pop);

   // Next pointer/occupancy after this cycle's pop and push.
   always_comb begin
      rd_ptr_n        = rd_ptr + PTR_W'(pop);
      count_after_pop = count - CNT_W'(pop);
      count_n         = count_after_pop + CNT_W'(push_accept_c);
   end

   // Storage array; no reset needed, entries are qualified by count.
   always_ff @(posedge clk) begin
      if (push_accept_c) mem[wr_ptr] <= wr_data;
   end

   // Pointers, occupancy and the registered head. When the queue drains to
   // empty while pushing, the new head is the incoming word itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         rd_data   <= '0;
      end else begin
         wr_ptr    <= wr_ptr + PTR_W'(push_accept_c);
         rd_ptr    <= rd_ptr_n;
         count     <= count_n;
         out_valid <= (count_n != '0);
         if (count_n != '0) begin
            rd_data <= (count_after_pop == '0) ? wr_data : mem[rd_ptr_n];
         end
      end
   end

endmodule

// File: rtl/privacy_release_unit.sv
// Chooses noisy or clean class per done_in under one of four release policies
// and queues each decision for the SoC result bus.
//   secure_mode_active, inject_noise, mode : policy inputs, sampled at done_in
//   class_in / class_a                     : noise-injected / clean class
//   budget_load, budget_value              : privacy-budget reload
//   out_valid/out_ready                    : output handshake
//   predicted_class, noise_applied         : registered queue head
//   budget_remaining, budget_exhausted     : registered budget status
//   overflow                               : sticky, a result was dropped
module privacy_release_unit
   import privacy_pkg::*;
#(
   parameter int unsigned CLASS_W     = 4,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned BUDGET_W    = 8,
   parameter int unsigned BUDGET_INIT = 8,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                secure_mode_active,
   input  logic                inject_noise,
   input  logic [1:0]          mode,
   input  logic [CLASS_W-1:0]  class_in,
   input  logic [CLASS_W-1:0]  class_a,
   input  logic                done_in,
   input  logic                budget_load,
   input  logic [BUDGET_W-1:0] budget_value,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [CLASS_W-1:0]  predicted_class,
   output logic                noise_applied,
   output logic [BUDGET_W-1:0] budget_remaining,
   output logic                budget_exhausted,
   output logic                overflow
);

   localparam int unsigned ENTRY_W = CLASS_W + 1;

   release_mode_e       mode_e;
   logic [15:0]         lfsr;
   logic                use_noise_c;
   logic                consume_c;
   logic                push_accept_c;
   logic [ENTRY_W-1:0]  entry_c;
   logic [ENTRY_W-1:0]  head;
   logic [BUDGET_W-1:0] budget_n;

   assign mode_e = release_mode_e'(mode);

   // Release policy decision for the current done_in.
   always_comb begin
      use_noise_c = 1'b0;
      case (mode_e)
         REL_PASS:   use_noise_c = 1'b0;
         REL_GATED:  use_noise_c = secure_mode_active & inject_noise;
         REL_RANDOM: use_noise_c = secure_mode_active & (lfsr[1:0] != 2'b00);
         REL_BUDGET: use_noise_c = secure_mode_active & (budget_remaining == '0);
         default:    use_noise_c = 1'b0;
      endcase
   end

   assign entry_c = {use_noise_c ? class_in : class_a, use_noise_c};

   // A clean secure release in BUDGET mode spends one unit, only if queued.
   assign consume_c = done_in & push_accept_c & (mode_e == REL_BUDGET) &
                      secure_mode_active & !use_noise_c;

   // Reload has priority over consumption; the counter saturates at zero.
   always_comb begin
      budget_n = budget_remaining;
      if (budget_load) begin
         budget_n = budget_value;
      end else if (consume_c && (budget_remaining != '0)) begin
         budget_n = budget_remaining - BUDGET_W'(1);
      end
   end

   // Budget status, overflow flag and free-running LFSR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         budget_remaining <= BUDGET_W'(BUDGET_INIT);
         budget_exhausted <= (BUDGET_W'(BUDGET_INIT) == '0);
         overflow         <= 1'b0;
         lfsr             <= LFSR_SEED;
      end else begin
         budget_remaining <= budget_n;
         budget_exhausted <= (budget_n == '0);
         overflow         <= overflow | (done_in & !push_accept_c);
         lfsr             <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
      end
   end

   privacy_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .push          (done_in),
      .wr_data       (entry_c),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .rd_data       (head),
      .push_accept_c (push_accept_c)
   );

   assign predicted_class = head[ENTRY_W-1:1];
   assign noise_applied   = head[0];

endmodule

// File: tb/tb_privacy_release_unit.sv
module tb_privacy_release_unit;

   localparam int unsigned CLASS_W  = 4;
   localparam int unsigned BUDGET_W = 8;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                secure_mode_active = 1'b0;
   logic                inject_noise = 1'b0;
   logic [1:0]          mode = 2'd0;
   logic [CLASS_W-1:0]  class_in = '0;
   logic [CLASS_W-1:0]  class_a = '0;
   logic                done_in = 1'b0;
   logic                budget_load = 1'b0;
   logic [BUDGET_W-1:0] budget_value = '0;
   logic                out_ready = 1'b0;
   logic                out_valid;
   logic [CLASS_W-1:0]  predicted_class;
   logic                noise_applied;
   logic [BUDGET_W-1:0] budget_remaining;
   logic                budget_exhausted;
   logic                overflow;

   int n_checks = 0;
   int n_fail   = 0;

   privacy_release_unit #(
      .CLASS_W     (CLASS_W),
      .FIFO_DEPTH  (4),
      .BUDGET_W    (BUDGET_W),
      .BUDGET_INIT (8),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .secure_mode_active (secure_mode_active),
      .inject_noise       (inject_noise),
      .mode               (mode),
      .class_in           (class_in),
      .class_a            (class_a),
      .done_in            (done_in),
      .budget_load        (budget_load),
      .budget_value       (budget_value),
      .out_ready          (out_ready),
      .out_valid          (out_valid),
      .predicted_class    (predicted_class),
      .noise_applied      (noise_applied),
      .budget_remaining   (budget_remaining),
      .budget_exhausted   (budget_exhausted),
      .overflow           (overflow)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^16+x^14+x^13+x^11, shifting right every cycle.
   logic [15:0] m_lfsr;
   always @(posedge clk or posedge reset) begin
      if (reset) m_lfsr <= 16'hACE1;
      else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end

   typedef struct {
      logic       sec;
      logic       inj;
      logic [1:0] md;
      logic [3:0] ci;
      logic [3:0] ca;
      logic [3:0] exp_cls;
      logic       exp_noise;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int noisy;
      logic exp_n;

      vecs[0] = '{1'b1, 1'b1, 2'd0, 4'd5, 4'd2, 4'd2, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 2'd1, 4'd5, 4'd2, 4'd5, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 2'd1, 4'd5, 4'd2, 4'd2, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 2'd1, 4'd5, 4'd2, 4'd2, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 2'd2, 4'd9, 4'd3, 4'd3, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 2'd3, 4'd7, 4'd4, 4'd4, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 2'd3, 4'd7, 4'd4, 4'd4, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 2'd1, 4'd15, 4'd0, 4'd15, 1'b1};

      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_class", predicted_class, 0);
      check("rst_noise", noise_applied, 0);
      check("rst_overflow", overflow, 0);
      check("rst_budget", budget_remaining, 8);
      check("rst_exhausted", budget_exhausted, 0);

      // Single-result vectors across policies
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         secure_mode_active = vecs[i].sec;
         inject_noise       = vecs[i].inj;
         mode               = vecs[i].md;
         class_in           = vecs[i].ci;
         class_a            = vecs[i].ca;
         done_in            = 1'b1;
         tick();
         done_in = 1'b0;
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_class", i), predicted_class, vecs[i].exp_cls);
         check($sformatf("vec%0d_noise", i), noise_applied, vecs[i].exp_noise);
         tick();
         check($sformatf("vec%0d_drained", i), out_valid, 0);
      end
      check("vec_budget_after", budget_remaining, 7);

      // BUDGET sequence: load 2, four back-to-back results
      budget_load  = 1'b1;
      budget_value = 8'd2;
      tick();
      budget_load = 1'b0;
      check("bud_loaded", budget_remaining, 2);
      secure_mode_active = 1'b1;
      mode     = 2'd3;
      class_in = 4'd5;
      class_a  = 4'd2;
      done_in  = 1'b1;
      tick();
      check("bud1_class", predicted_class, 2);
      check("bud1_budget", budget_remaining, 1);
      check("bud1_exh", budget_exhausted, 0);
      tick();
      check("bud2_class", predicted_class, 2);
      check("bud2_budget", budget_remaining, 0);
      check("bud2_exh", budget_exhausted, 1);
      tick();
      check("bud3_class", predicted_class, 5);
      check("bud3_noise", noise_applied, 1);
      check("bud3_budget", budget_remaining, 0);
      tick();
      check("bud4_class", predicted_class, 5);
      check("bud4_noise", noise_applied, 1);
      done_in = 1'b0;
      tick();
      check("bud_drained", out_valid, 0);

      // Load wins over a coincident clean release
      budget_load  = 1'b1;
      budget_value = 8'd3;
      tick();
      budget_value = 8'd7;
      done_in      = 1'b1;
      tick();
      budget_load = 1'b0;
      done_in     = 1'b0;
      check("coll_class", predicted_class, 2);
      check("coll_noise", noise_applied, 0);
      check("coll_budget", budget_remaining, 7);
      tick();

      // Overflow with backpressure
      mode      = 2'd0;
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         class_a = 4'(i);
         done_in = 1'b1;
         tick();
         check($sformatf("ovf_flag_push%0d", i), overflow, (i == 5) ? 1 : 0);
      end
      done_in = 1'b0;
      check("ovf_head_valid", out_valid, 1);
      check("ovf_head_class", predicted_class, 1);
      out_ready = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         tick();
         check($sformatf("ovf_drain_valid%0d", k), out_valid, 1);
         check($sformatf("ovf_drain_class%0d", k), predicted_class, k);
      end
      tick();
      check("ovf_empty", out_valid, 0);
      check("ovf_hold_class", predicted_class, 4);
      check("ovf_sticky", overflow, 1);

      // Reset mid-operation with entries queued and budget 5
      out_ready    = 1'b0;
      budget_load  = 1'b1;
      budget_value = 8'd5;
      tick();
      budget_load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         class_a = 4'd6;
         done_in = 1'b1;
         tick();
      end
      done_in = 1'b0;
      check("mid_pre_valid", out_valid, 1);
      check("mid_pre_budget", budget_remaining, 5);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_budget", budget_remaining, 8);
      check("mid_rst_overflow", overflow, 0);
      check("mid_rst_class", predicted_class, 0);
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      class_a   = 4'd3;
      done_in   = 1'b1;
      tick();
      done_in = 1'b0;
      check("post_rst_valid", out_valid, 1);
      check("post_rst_class", predicted_class, 3);
      tick();
      check("post_rst_drained", out_valid, 0);

      // Push plus pop on a full queue
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         class_a = 4'(i);
         done_in = 1'b1;
         tick();
      end
      class_a   = 4'd5;
      out_ready = 1'b1;
      tick();
      done_in = 1'b0;
      check("full_pp_overflow", overflow, 0);
      check("full_pp_class", predicted_class, 2);
      for (int k = 3; k <= 5; k++) begin
         tick();
         check($sformatf("full_pp_class%0d", k), predicted_class, k);
      end
      tick();
      check("full_pp_empty", out_valid, 0);

      // RANDOM mode against the reference LFSR
      secure_mode_active = 1'b1;
      mode     = 2'd2;
      class_in = 4'd9;
      class_a  = 4'd6;
      noisy    = 0;
      for (int i = 0; i < 64; i++) begin
         exp_n   = (m_lfsr[1:0] != 2'b00);
         done_in = 1'b1;
         tick();
         check($sformatf("rand%0d_noise", i), noise_applied, exp_n);
         check($sformatf("rand%0d_class", i), predicted_class, exp_n ? 9 : 6);
         if (noise_applied) noisy++;
      end
      done_in = 1'b0;
      tick();
      check("rand_count_in_range", (noisy >= 40 && noisy <= 56) ? 1 : 0, 1);
      check("rand_no_overflow", overflow, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
